// File: rtl/pdua_mem_pkg.sv
// rtl/pdua_mem_pkg.sv - shared encodings for the PDUA memory-port sequencer
package pdua_mem_pkg;

    localparam int WCNT_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_e;

    localparam logic GNT_F = 1'b0;
    localparam logic GNT_D = 1'b1;

endpackage

// File: rtl/mar_bus_arbiter_rr_arb2.sv
// rtl/mar_bus_arbiter_rr_arb2.sv - two-way round-robin arbiter with advance handshake
module rr_arb2
    import pdua_mem_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req_f,
    input  logic req_d,
    input  logic advance,
    output logic gnt_valid,
    output logic gnt_id
);

    logic ptr_q;
    logic ptr_d;

    // Grant follows the lone requester; on contention the pointer decides.
    // The pointer only moves when the caller accepts the grant.
    always_comb begin
        gnt_valid = req_f | req_d;
        if (req_f && req_d) begin
            gnt_id = ptr_q;
        end else if (req_d) begin
            gnt_id = GNT_D;
        end else begin
            gnt_id = GNT_F;
        end
        ptr_d = ptr_q;
        if (advance && gnt_valid) begin
            ptr_d = ~gnt_id;
        end
    end

    // Pointer register; reset favours the fetch side.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= GNT_F;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/mar_bus_arbiter.sv
// rtl/mar_bus_arbiter.sv - MAR and memory strobe sequencer shared by fetch and data ports
module mar_bus_arbiter
    import pdua_mem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 8,
    parameter int WAIT_STATES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  soft_clr,
    input  logic                  f_req,
    input  logic [ADDR_WIDTH-1:0] f_addr,
    output logic                  f_done,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_done,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  mar_ena,
    output logic                  mar_sclr,
    output logic [ADDR_WIDTH-1:0] mar_d,
    output logic                  mem_rd,
    output logic                  mem_wr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam logic [WCNT_W-1:0] WS_INIT  = WCNT_W'(WAIT_STATES);
    localparam logic [WCNT_W-1:0] WCNT_ONE = WCNT_W'(1);

    state_e                state_q, state_d;
    logic [WCNT_W-1:0]     wcnt_q, wcnt_d;
    logic                  gnt_q, gnt_d;
    logic                  we_q, we_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic arb_valid;
    logic arb_id;
    logic arb_advance;

    rr_arb2 u_arb (
        .clk       (clk),
        .rst       (rst),
        .req_f     (f_req),
        .req_d     (d_req),
        .advance   (arb_advance),
        .gnt_valid (arb_valid),
        .gnt_id    (arb_id)
    );

    // State and datapath latches; async reset returns everything to idle/zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            wcnt_q  <= '0;
            gnt_q   <= GNT_F;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            gnt_q   <= gnt_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Next-state logic; soft_clr aborts from any state without touching pointer or rdata.
    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        gnt_d       = gnt_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        arb_advance = 1'b0;
        if (soft_clr) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (arb_valid) begin
                        gnt_d       = arb_id;
                        arb_advance = 1'b1;
                        state_d     = LOAD;
                    end
                end
                LOAD: begin
                    // Fetches are always reads, whatever d_we happens to be.
                    we_d    = (gnt_q == GNT_D) && d_we;
                    wdata_d = d_wdata;
                    wcnt_d  = WS_INIT;
                    state_d = ACCESS;
                end
                ACCESS: begin
                    if (wcnt_q == '0) begin
                        if (!we_q) begin
                            rdata_d = mem_rdata;
                        end
                        state_d = DONE;
                    end else begin
                        wcnt_d = wcnt_q - WCNT_ONE;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Output decodes from registered state; request inputs never reach the strobes.
    always_comb begin
        mar_ena   = (state_q == LOAD) && !soft_clr;
        mar_sclr  = soft_clr && !rst;
        mar_d     = '0;
        if (state_q == LOAD) begin
            mar_d = (gnt_q == GNT_D) ? d_addr : f_addr;
        end
        mem_rd    = (state_q == ACCESS) && !we_q;
        mem_wr    = (state_q == ACCESS) && we_q;
        mem_wdata = mem_wr ? wdata_q : '0;
        f_done    = (state_q == DONE) && !soft_clr && (gnt_q == GNT_F);
        d_done    = (state_q == DONE) && !soft_clr && (gnt_q == GNT_D);
        rdata     = rdata_q;
    end

endmodule
